xgmii_rx_deframer: RTL and testbench

Receive-side counterpart to the PTP transmit buffer. It consumes a 64-bit XGMII stream (for example the looped-back xge_txd/xge_txc of the tx path), validates the start/preamble/SFD word, strips it, and emits frame payload as a 64-bit beat stream with sop/eop/byte-count. It also reports per-frame length and status, and keeps saturating good and errored frame counters. Downstream consumers are the PTP rx buffer and parser. No FCS check is done; FCS bytes are passed through as payload.

---
 rtl/xgmii_rx_deframer.sv | 204 ++++++++++++++++++++
 tb/tb_xgmii_rx_deframer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_deframer.sv
// rtl/xgmii_rx_deframer.sv - XGMII receive deframer: start/preamble strip, payload beats, frame status and counters
module xgmii_rx_deframer #(
   parameter int MAX_FRM_LEN = 512
) (
   input  logic        rx_clk,
   input  logic        rx_rst,
   input  logic [63:0] xge_rxd_i,
   input  logic [7:0]  xge_rxc_i,
   output logic [63:0] rx_data_o,
   output logic        rx_valid_o,
   output logic        rx_sop_o,
   output logic        rx_eop_o,
   output logic [2:0]  rx_mod_o,
   output logic        rx_err_o,
   output logic        frm_done_o,
   output logic [15:0] frm_len_o,
   output logic [15:0] frm_cnt_o,
   output logic [15:0] err_cnt_o
);

   localparam logic [7:0]  C_START    = 8'hFB;
   localparam logic [7:0]  C_TERM     = 8'hFD;
   localparam logic [63:0] START_WORD = 64'hD555_5555_5555_55FB;
   localparam logic [16:0] MAX_LEN    = 17'(MAX_FRM_LEN);

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_DROP} state_t;

   state_t      state_q;
   logic [63:0] hold_q;
   logic        hold_vld_q;
   logic        first_q;
   logic        pend_q;
   logic        pend_sop_q;
   logic [2:0]  pend_mod_q;
   logic [15:0] cnt_q;

   logic [63:0] rx_data_q;
   logic        rx_valid_q, rx_sop_q, rx_eop_q, rx_err_q, frm_done_q;
   logic [2:0]  rx_mod_q;
   logic [15:0] frm_len_q, frm_cnt_q, err_cnt_q;

   logic        start_ok, start_l0, has_ctl, term_first, any_term;
   logic        w_full, w_term;
   logic [2:0]  ctl_lane;
   logic [7:0]  ctl_byte;
   logic [63:0] part_data;
   logic [16:0] cnt_full_d, cnt_part_d;

   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign rx_sop_o   = rx_sop_q;
   assign rx_eop_o   = rx_eop_q;
   assign rx_mod_o   = rx_mod_q;
   assign rx_err_o   = rx_err_q;
   assign frm_done_o = frm_done_q;
   assign frm_len_o  = frm_len_q;
   assign frm_cnt_o  = frm_cnt_q;
   assign err_cnt_o  = err_cnt_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Classify the incoming word: start word, lowest control lane, terminate position and length limits
   always_comb begin
      start_ok = (xge_rxc_i == 8'h01) && (xge_rxd_i == START_WORD);
      start_l0 = xge_rxc_i[0] && (xge_rxd_i[7:0] == C_START);
      has_ctl  = |xge_rxc_i;
      ctl_lane = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (xge_rxc_i[k]) ctl_lane = 3'(k);
      end
      ctl_byte   = xge_rxd_i[{ctl_lane, 3'b000} +: 8];
      term_first = has_ctl && (ctl_byte == C_TERM);
      any_term   = 1'b0;
      part_data  = '0;
      for (int k = 0; k < 8; k++) begin
         if (xge_rxc_i[k] && (xge_rxd_i[8*k +: 8] == C_TERM)) any_term = 1'b1;
         if (k < int'(ctl_lane)) part_data[8*k +: 8] = xge_rxd_i[8*k +: 8];
      end
      cnt_full_d = {1'b0, cnt_q} + 17'd8;
      cnt_part_d = {1'b0, cnt_q} + {14'd0, ctl_lane};
      w_full     = !has_ctl && (cnt_full_d <= MAX_LEN);
      w_term     = term_first && (cnt_part_d <= MAX_LEN);
   end

   // Frame FSM, one-word hold pipeline, registered beat/status outputs and saturating counters
   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         state_q    <= RX_IDLE;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         first_q    <= 1'b0;
         pend_q     <= 1'b0;
         pend_sop_q <= 1'b0;
         pend_mod_q <= '0;
         cnt_q      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_sop_q   <= 1'b0;
         rx_eop_q   <= 1'b0;
         rx_mod_q   <= '0;
         rx_err_q   <= 1'b0;
         frm_done_q <= 1'b0;
         frm_len_q  <= '0;
         frm_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_sop_q   <= 1'b0;
         rx_eop_q   <= 1'b0;
         rx_mod_q   <= '0;
         rx_err_q   <= 1'b0;
         frm_done_q <= 1'b0;

         // A partial last word held from the previous cycle completes regardless of the new input
         if (pend_q) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= hold_q;
            rx_sop_q   <= pend_sop_q;
            rx_eop_q   <= 1'b1;
            rx_mod_q   <= pend_mod_q;
            frm_done_q <= 1'b1;
            frm_len_q  <= cnt_q;
            frm_cnt_q  <= sat_inc(frm_cnt_q);
            pend_q     <= 1'b0;
         end

         case (state_q)
            RX_IDLE: begin
               if (start_ok) begin
                  state_q    <= RX_DATA;
                  cnt_q      <= '0;
                  first_q    <= 1'b1;
                  hold_vld_q <= 1'b0;
               end else if (start_l0) begin
                  err_cnt_q <= sat_inc(err_cnt_q);
               end
            end
            RX_DATA: begin
               if (w_full) begin
                  if (hold_vld_q) begin
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= hold_q;
                     rx_sop_q   <= first_q;
                     first_q    <= 1'b0;
                  end
                  hold_q     <= xge_rxd_i;
                  hold_vld_q <= 1'b1;
                  cnt_q      <= cnt_full_d[15:0];
               end else if (w_term && (ctl_lane == 3'd0)) begin
                  frm_done_q <= 1'b1;
                  frm_len_q  <= cnt_q;
                  state_q    <= RX_IDLE;
                  hold_vld_q <= 1'b0;
                  if (hold_vld_q) begin
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= hold_q;
                     rx_sop_q   <= first_q;
                     rx_eop_q   <= 1'b1;
                     frm_cnt_q  <= sat_inc(frm_cnt_q);
                  end else begin
                     rx_err_q  <= 1'b1;
                     err_cnt_q <= sat_inc(err_cnt_q);
                  end
               end else if (w_term) begin
                  if (hold_vld_q) begin
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= hold_q;
                     rx_sop_q   <= first_q;
                  end
                  hold_q     <= part_data;
                  pend_q     <= 1'b1;
                  pend_mod_q <= ctl_lane;
                  pend_sop_q <= first_q && !hold_vld_q;
                  first_q    <= 1'b0;
                  cnt_q      <= cnt_part_d[15:0];
                  state_q    <= RX_IDLE;
                  hold_vld_q <= 1'b0;
               end else begin
                  frm_done_q <= 1'b1;
                  rx_err_q   <= 1'b1;
                  frm_len_q  <= cnt_q;
                  err_cnt_q  <= sat_inc(err_cnt_q);
                  state_q    <= RX_DROP;
                  hold_vld_q <= 1'b0;
                  if (hold_vld_q) begin
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= hold_q;
                     rx_sop_q   <= first_q;
                     rx_eop_q   <= 1'b1;
                  end
               end
            end
            RX_DROP: begin
               if (any_term || start_ok) state_q <= RX_IDLE;
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// tb/tb_xgmii_rx_deframer.sv - self-checking bench for xgmii_rx_deframer against a frame-level timeline model
module tb_xgmii_rx_deframer;

   localparam int MAX  = 64;
   localparam int NEXP = 4096;

   localparam logic [63:0] IDLE_W  = {8{8'h07}};
   localparam logic [63:0] START_W = 64'hD555_5555_5555_55FB;
   localparam logic [63:0] TERM0_W = {{7{8'h07}}, 8'hFD};

   logic        rx_clk = 1'b0;
   logic        rx_rst;
   logic [63:0] xge_rxd_i;
   logic [7:0]  xge_rxc_i;
   logic [63:0] rx_data_o;
   logic        rx_valid_o, rx_sop_o, rx_eop_o, rx_err_o, frm_done_o;
   logic [2:0]  rx_mod_o;
   logic [15:0] frm_len_o, frm_cnt_o, err_cnt_o;

   xgmii_rx_deframer #(.MAX_FRM_LEN(MAX)) dut (
      .rx_clk     (rx_clk),
      .rx_rst     (rx_rst),
      .xge_rxd_i  (xge_rxd_i),
      .xge_rxc_i  (xge_rxc_i),
      .rx_data_o  (rx_data_o),
      .rx_valid_o (rx_valid_o),
      .rx_sop_o   (rx_sop_o),
      .rx_eop_o   (rx_eop_o),
      .rx_mod_o   (rx_mod_o),
      .rx_err_o   (rx_err_o),
      .frm_done_o (frm_done_o),
      .frm_len_o  (frm_len_o),
      .frm_cnt_o  (frm_cnt_o),
      .err_cnt_o  (err_cnt_o)
   );

   always #5 rx_clk = ~rx_clk;

   // Expected output of each clock edge, filled in per frame from its descriptor
   typedef struct {
      bit        valid, sop, eop, err, done, fc_inc, ec_inc;
      bit [2:0]  mod;
      bit [63:0] data;
      int        len;
   } exp_t;

   exp_t       exp_a [NEXP];
   int         edge_n, checks, errors;
   int         fc_run, ec_run, len_run;
   logic [7:0] pay [0:127];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s @edge%0d observed=0x%0h expected=0x%0h", tag, edge_n, obs, expv);
      end
   endtask

   function automatic void set_beat(int n, int first, int nb, bit sop, bit eop, bit err, int mod);
      if (n >= NEXP) return;
      exp_a[n].valid = 1'b1;
      exp_a[n].sop   = sop;
      exp_a[n].eop   = eop;
      exp_a[n].err   = err;
      exp_a[n].mod   = 3'(mod);
      exp_a[n].data  = '0;
      for (int b = 0; b < nb; b++) exp_a[n].data[8*b +: 8] = pay[first + b];
   endfunction

   function automatic void set_done(int n, int len, bit good);
      if (n >= NEXP) return;
      exp_a[n].done = 1'b1;
      exp_a[n].len  = len;
      if (good) exp_a[n].fc_inc = 1'b1;
      else begin
         exp_a[n].ec_inc = 1'b1;
         exp_a[n].err    = 1'b1;
      end
   endfunction

   function automatic logic [63:0] word_of(int base);
      logic [63:0] w;
      for (int b = 0; b < 8; b++) w[8*b +: 8] = pay[base + b];
      return w;
   endfunction

   // Drive one XGMII word, then compare every output with the timeline entry for that edge
   task automatic step(input logic [63:0] d, input logic [7:0] c);
      exp_t e;
      xge_rxd_i = d;
      xge_rxc_i = c;
      @(posedge rx_clk);
      edge_n++;
      #1;
      e = exp_a[edge_n];
      if (rx_rst) begin
         fc_run = 0; ec_run = 0; len_run = 0;
      end else begin
         if (e.fc_inc) fc_run++;
         if (e.ec_inc) ec_run++;
         if (e.done) len_run = e.len;
      end
      chk("valid",   rx_valid_o, e.valid);
      chk("sop",     rx_sop_o,   e.sop);
      chk("eop",     rx_eop_o,   e.eop);
      chk("mod",     rx_mod_o,   e.mod);
      chk("err",     rx_err_o,   e.err);
      chk("data",    rx_data_o,  e.data);
      chk("done",    frm_done_o, e.done);
      chk("frm_len", frm_len_o,  64'(len_run));
      chk("frm_cnt", frm_cnt_o,  64'(fc_run));
      chk("err_cnt", err_cnt_o,  64'(ec_run));
   endtask

   task automatic fill_incr(input int len);
      for (int i = 0; i < len; i++) pay[i] = 8'(i + 1);
   endtask

   task automatic fill_rand(input int len);
      for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
   endtask

   // Send one frame from pay[]; bad_mode 1 corrupts a preamble byte, 2 sets an extra rxc bit;
   // inj >= 0 places ERROR in lane inj_lane of full data word inj
   task automatic send_frame(input int len, input int inj, input int inj_lane,
                             input int bad_mode, input int bad_lane, input int gap);
      int nfull, k, ts, j, cnt_after, nb;
      logic [63:0] w;
      logic [7:0]  c;
      nfull = len / 8;
      k     = len % 8;
      ts    = edge_n + 1;
      j     = -1;
      if (bad_mode != 0) begin
         exp_a[ts].ec_inc = 1'b1;
      end else begin
         for (int i = 0; i <= nfull; i++) begin
            cnt_after = (i < nfull) ? 8 * (i + 1) : len;
            if (((i < nfull) && (i == inj)) || (cnt_after > MAX)) begin
               j = i;
               break;
            end
         end
         if (j >= 0) begin
            for (int i = 0; i < j; i++) set_beat(ts + 2 + i, 8 * i, 8, i == 0, i == j - 1, i == j - 1, 0);
            set_done(ts + 1 + j, 8 * j, 1'b0);
         end else if (len == 0) begin
            set_done(ts + 1, 0, 1'b0);
         end else begin
            nb = (k == 0) ? nfull : nfull + 1;
            for (int i = 0; i < nb; i++)
               set_beat(ts + 2 + i, 8 * i, (i == nfull) ? k : 8, i == 0, i == nb - 1, 1'b0, (i == nfull) ? k : 0);
            set_done(ts + 1 + nb, len, 1'b1);
         end
      end
      w = START_W;
      c = 8'h01;
      if (bad_mode == 1) w[8*bad_lane +: 8] = w[8*bad_lane +: 8] ^ 8'h01;
      if (bad_mode == 2) c = c | 8'(8'h01 << bad_lane);
      step(w, c);
      for (int i = 0; i < nfull; i++) begin
         w = word_of(8 * i);
         c = 8'h00;
         if (i == inj) begin
            w[8*inj_lane +: 8] = 8'hFE;
            c[inj_lane] = 1'b1;
         end
         step(w, c);
      end
      w = IDLE_W;
      for (int b = 0; b < k; b++) w[8*b +: 8] = pay[8 * nfull + b];
      w[8*k +: 8] = 8'hFD;
      step(w, 8'(8'hFF << k));
      if ((j >= 0) && (j == nfull)) step(TERM0_W, 8'hFF);
      repeat (gap) step(IDLE_W, 8'hFF);
   endtask

   initial begin
      int ts, len, r, inj, mode;
      checks = 0; errors = 0; edge_n = 0;
      fc_run = 0; ec_run = 0; len_run = 0;
      for (int i = 0; i < NEXP; i++) exp_a[i] = '{default: '0};
      rx_rst = 1'b1;
      xge_rxd_i = IDLE_W;
      xge_rxc_i = 8'hFF;
      repeat (3) step(IDLE_W, 8'hFF);
      rx_rst = 1'b0;
      step(IDLE_W, 8'hFF);

      // 64-byte frame with incrementing payload
      fill_incr(64);
      send_frame(64, -1, 0, 0, 0, 1);
      chk("t1_frm_cnt", frm_cnt_o, 64'd1);
      chk("t1_frm_len", frm_len_o, 64'd64);

      // 61-byte frame, terminate in lane 5
      fill_rand(61);
      send_frame(61, -1, 0, 0, 0, 1);
      chk("t2_frm_len", frm_len_o, 64'd61);

      // START in lane 4 is not a frame
      step({24'h070707, 8'hFB, 32'h07070707}, 8'hFF);

      // bad preamble lane 3 = 0x54, then a normal 64-byte frame
      fill_incr(64);
      send_frame(64, -1, 0, 1, 3, 0);
      chk("t3_err_cnt", err_cnt_o, 64'd1);
      send_frame(64, -1, 0, 0, 0, 1);

      // ERROR in lane 2 of data word 3
      fill_rand(64);
      send_frame(64, 2, 2, 0, 0, 1);
      chk("t4_frm_len", frm_len_o, 64'd16);

      // 72-byte frame over the 64-byte limit
      fill_rand(72);
      send_frame(72, -1, 0, 0, 0, 1);
      chk("t5_frm_len", frm_len_o, 64'd64);

      // reset after data word 3, then a normal frame
      fill_incr(64);
      ts = edge_n + 1;
      set_beat(ts + 2, 0, 8, 1'b1, 1'b0, 1'b0, 0);
      set_beat(ts + 3, 8, 8, 1'b0, 1'b0, 1'b0, 0);
      step(START_W, 8'h01);
      for (int i = 0; i < 3; i++) step(word_of(8 * i), 8'h00);
      rx_rst = 1'b1;
      step(IDLE_W, 8'hFF);
      rx_rst = 1'b0;
      chk("t6_err_cnt", err_cnt_o, 64'd0);
      step(IDLE_W, 8'hFF);
      send_frame(64, -1, 0, 0, 0, 1);

      // short, zero-length and back-to-back frames
      fill_rand(8);
      send_frame(3, -1, 0, 0, 0, 0);
      send_frame(0, -1, 0, 0, 0, 0);
      send_frame(8, -1, 0, 0, 0, 0);
      send_frame(8, 0, 5, 0, 0, 1);

      // randomized frames
      for (int f = 0; f < 40; f++) begin
         len  = $urandom_range(0, 90);
         r    = $urandom_range(0, 9);
         inj  = -1;
         mode = 0;
         if (r == 0) mode = $urandom_range(1, 2);
         else if ((r <= 2) && (len >= 8)) inj = $urandom_range(0, len / 8 - 1);
         fill_rand(len);
         send_frame(len, inj, $urandom_range(0, 7), mode, $urandom_range(1, 7), $urandom_range(0, 2));
      end
      repeat (4) step(IDLE_W, 8'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
